// File: rtl/codec_sched_pkg.sv
// codec_sched_pkg: shared types and constants for the codec output scheduler.
package codec_sched_pkg;
    localparam int DEF_DATA_W = 16;
    typedef enum logic [1:0] {
        SILENT   = 2'd0,
        FADE_IN  = 2'd1,
        PLAY     = 2'd2,
        FADE_OUT = 2'd3
    } state_e;
    typedef struct packed {
        logic signed [DEF_DATA_W-1:0] lft;
        logic signed [DEF_DATA_W-1:0] rht;
    } pair_t;
    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;
endpackage

// File: rtl/codec_src_buf.sv
// codec_src_buf: one-entry valid/ready sample buffer, emptied by clr.
module codec_src_buf
    import codec_sched_pkg::*;
#(
    parameter int W = 2 * DEF_DATA_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         vld,
    input  logic [W-1:0] din,
    input  logic         clr,
    output logic         rdy,
    output logic [W-1:0] dout
);
    logic full;
    assign rdy = !full;
    // A load into an empty buffer wins over clr, so a sample offered in a tick cycle is kept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full <= 1'b0;
            dout <= '0;
        end else if (vld && !full) begin
            full <= 1'b1;
            dout <= din;
        end else if (clr) begin
            full <= 1'b0;
        end
    end
endmodule

// File: rtl/codec_out_sched.sv
// codec_out_sched: shares the codec output slot between sources A/B with linear gain fades.
// Define CODEC_UNDERRUN_CNT_EN to add the saturating underrun_cnt output.
module codec_out_sched
    import codec_sched_pkg::*;
#(
    parameter int FADE_LOG2 = 4,
    parameter int DATA_W    = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_tick,
    input  logic              en,
    input  logic              sel,
    input  logic              a_vld,
    input  logic [DATA_W-1:0] a_lft,
    input  logic [DATA_W-1:0] a_rht,
    output logic              a_rdy,
    input  logic              b_vld,
    input  logic [DATA_W-1:0] b_lft,
    input  logic [DATA_W-1:0] b_rht,
    output logic              b_rdy,
    output logic [DATA_W-1:0] lft_out,
    output logic [DATA_W-1:0] rht_out,
    output logic              active_src,
    output logic              busy,
    output logic              underrun
`ifdef CODEC_UNDERRUN_CNT_EN
    ,
    output logic [15:0]       underrun_cnt
`endif
);
    localparam int GW = FADE_LOG2 + 1;
    localparam int PW = DATA_W + FADE_LOG2 + 1;
    localparam logic [GW-1:0] FULL = GW'(1) << FADE_LOG2;

    logic [2*DATA_W-1:0] a_dat, b_dat, act;
    logic                act_full, leave;
    logic [GW-1:0]       gain, gain_n;
    logic                src_n;
    state_e              state, state_n;
    logic signed [PW-1:0] g_s, prod_l, prod_r;

    codec_src_buf #(.W(2 * DATA_W)) u_buf_a (
        .clk(clk), .rst(rst), .vld(a_vld), .din({a_lft, a_rht}),
        .clr(frame_tick), .rdy(a_rdy), .dout(a_dat)
    );
    codec_src_buf #(.W(2 * DATA_W)) u_buf_b (
        .clk(clk), .rst(rst), .vld(b_vld), .din({b_lft, b_rht}),
        .clr(frame_tick), .rdy(b_rdy), .dout(b_dat)
    );

    assign act_full = (active_src == SRC_B) ? !b_rdy : !a_rdy;
    assign act      = (active_src == SRC_B) ? b_dat : a_dat;
    assign leave    = !en || (sel != active_src);
    assign busy     = (state == FADE_IN) || (state == FADE_OUT);

    // Empty active buffer scales as a zero sample.
    assign g_s    = PW'($signed({1'b0, gain}));
    assign prod_l = act_full ? PW'($signed(act[2*DATA_W-1:DATA_W])) * g_s : '0;
    assign prod_r = act_full ? PW'($signed(act[DATA_W-1:0])) * g_s : '0;

    always_comb begin
        state_n = state;
        gain_n  = gain;
        src_n   = active_src;
        case (state)
            SILENT: if (en) begin
                state_n = FADE_IN;
                src_n   = sel;
            end
            FADE_IN: if (leave) begin
                state_n = FADE_OUT;
            end else begin
                gain_n  = gain + GW'(1);
                state_n = (gain_n == FULL) ? PLAY : FADE_IN;
            end
            PLAY: state_n = leave ? FADE_OUT : PLAY;
            FADE_OUT: begin
                gain_n = (gain == '0) ? '0 : gain - GW'(1);
                if (gain_n == '0) begin
                    state_n = en ? FADE_IN : SILENT;
                    src_n   = en ? sel : active_src;
                end
            end
            default: state_n = SILENT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= SILENT;
            gain       <= '0;
            active_src <= SRC_A;
            lft_out    <= '0;
            rht_out    <= '0;
            underrun   <= 1'b0;
        end else if (frame_tick) begin
            state      <= state_n;
            gain       <= gain_n;
            active_src <= src_n;
            lft_out    <= DATA_W'(prod_l >>> FADE_LOG2);
            rht_out    <= DATA_W'(prod_r >>> FADE_LOG2);
            underrun   <= (state != SILENT) && !act_full;
        end else begin
            underrun   <= 1'b0;
        end
    end

`ifdef CODEC_UNDERRUN_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) underrun_cnt <= '0;
        else if (underrun && underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_codec_out_sched.sv
// tb_codec_out_sched: directed self-checking bench for codec_out_sched.
module tb_codec_out_sched;
    logic clk = 1'b0, rst = 1'b1, frame_tick = 1'b0, en = 1'b0, sel = 1'b0;
    logic a_vld = 1'b0, b_vld = 1'b0;
    logic [15:0] a_lft = '0, a_rht = '0, b_lft = '0, b_rht = '0;
    logic [15:0] lft_out, rht_out;
    logic a_rdy, b_rdy, active_src, busy, underrun;
`ifdef CODEC_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt;
`endif
    int checks = 0;
    int failures = 0;

    codec_out_sched dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .en(en), .sel(sel),
        .a_vld(a_vld), .a_lft(a_lft), .a_rht(a_rht), .a_rdy(a_rdy),
        .b_vld(b_vld), .b_lft(b_lft), .b_rht(b_rht), .b_rdy(b_rdy),
        .lft_out(lft_out), .rht_out(rht_out), .active_src(active_src),
        .busy(busy), .underrun(underrun)
`ifdef CODEC_UNDERRUN_CNT_EN
        , .underrun_cnt(underrun_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, want);
        end
    endtask

    // Offer one pair per source (when enabled), then pulse frame_tick; returns at the negedge after the tick.
    task automatic frame(input logic av, input logic [15:0] al, input logic [15:0] ar,
                         input logic bv, input logic [15:0] bl, input logic [15:0] br);
        @(negedge clk);
        a_vld = av; a_lft = al; a_rht = ar;
        b_vld = bv; b_lft = bl; b_rht = br;
        @(negedge clk);
        a_vld = 1'b0; b_vld = 1'b0; frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_lft", lft_out, 0);
        chk("rst_rht", rht_out, 0);
        chk("rst_a_rdy", a_rdy, 1);
        chk("rst_b_rdy", b_rdy, 1);
        chk("rst_active", active_src, 0);
        chk("rst_busy", busy, 0);
        chk("rst_underrun", underrun, 0);
        rst = 1'b0;

        // Fade-in on A: SILENT tick, then ticks 1..17 ramp 0x0000 .. 0x4000.
        en = 1'b1; sel = 1'b0;
        frame(1, 16'h4000, 16'h2000, 1, 16'hC000, 16'hC000);
        chk("fi_tick0_busy", busy, 1);
        chk("fi_tick0_lft", lft_out, 0);
        for (int k = 1; k <= 17; k++) begin
            frame(1, 16'h4000, 16'h2000, 1, 16'hC000, 16'hC000);
            chk("fi_lft", lft_out, 32'(16'(32'h400 * (k - 1))));
            chk("fi_rht", rht_out, 32'(16'(32'h200 * (k - 1))));
            chk("fi_busy", busy, (k < 16) ? 1 : 0);
            chk("fi_underrun", underrun, 0);
        end
        frame(1, 16'h4000, 16'h2000, 1, 16'hC000, 16'hC000);
        chk("play_hold", lft_out, 16'h4000);

        // Underrun in PLAY: one withheld frame.
        frame(0, 16'h4000, 16'h2000, 1, 16'hC000, 16'hC000);
        chk("ur_lft", lft_out, 0);
        chk("ur_pulse", underrun, 1);
        @(negedge clk);
        chk("ur_one_cycle", underrun, 0);
`ifdef CODEC_UNDERRUN_CNT_EN
        chk("ur_cnt1", underrun_cnt, 1);
`endif
        frame(1, 16'h4000, 16'h2000, 1, 16'hC000, 16'hC000);
        chk("ur_resume", lft_out, 16'h4000);
        chk("ur_clear", underrun, 0);

        // Switch A->B: PLAY tick, 16 fade-out ticks of A, 16 fade-in ticks of B, then full B.
        sel = 1'b1;
        frame(1, 16'h4000, 16'h2000, 1, 16'hC000, 16'hC000);
        chk("sw_t0_lft", lft_out, 16'h4000);
        chk("sw_t0_busy", busy, 1);
        for (int t = 1; t <= 33; t++) begin
            frame(1, 16'h4000, 16'h2000, 1, 16'hC000, 16'hC000);
            if (t <= 16) chk("sw_down", lft_out, 32'(16'(32'h400 * (17 - t))));
            else chk("sw_up", lft_out, 32'(16'(-(32'h400 * (t - 17)))));
            chk("sw_active", active_src, (t >= 16) ? 1 : 0);
            chk("sw_busy", busy, (t < 32) ? 1 : 0);
        end
        chk("sw_final", lft_out, 16'hC000);

        // Offer in the tick cycle with B full: refused; b_rdy rises right after.
        @(negedge clk);
        b_vld = 1'b1; b_lft = 16'hC000; b_rht = 16'hC000;
        @(negedge clk);
        chk("sim_full_rdy0", b_rdy, 0);
        b_lft = 16'h1111; b_rht = 16'h1111; frame_tick = 1'b1;
        @(negedge clk);
        b_vld = 1'b0; frame_tick = 1'b0;
        chk("sim_full_rdy1", b_rdy, 1);
        chk("sim_full_out", lft_out, 16'hC000);
        // Offer in the tick cycle with B empty: accepted, underrun flagged, held for next tick.
        @(negedge clk);
        b_vld = 1'b1; b_lft = 16'h2000; b_rht = 16'h1000; frame_tick = 1'b1;
        @(negedge clk);
        b_vld = 1'b0; frame_tick = 1'b0;
        chk("sim_empty_rdy", b_rdy, 0);
        chk("sim_empty_ur", underrun, 1);
        chk("sim_empty_out", lft_out, 0);
`ifdef CODEC_UNDERRUN_CNT_EN
        @(negedge clk);
        chk("ur_cnt2", underrun_cnt, 2);
`endif
        frame(0, 16'h0, 16'h0, 0, 16'h0, 16'h0);
        chk("sim_held_lft", lft_out, 16'h2000);
        chk("sim_held_rht", rht_out, 16'h1000);
        chk("sim_held_ur", underrun, 0);

        // Fade out B with en=0; after 9 fade-out ticks gain is 7 (last output used gain 8).
        en = 1'b0;
        for (int t = 0; t <= 9; t++) frame(1, 16'h0, 16'h0, 1, 16'h2000, 16'h2000);
        chk("mf_lft", lft_out, 16'h1000);
        chk("mf_busy", busy, 1);
        @(negedge clk);
        a_vld = 1'b1; a_lft = 16'h1234;
        @(negedge clk);
        a_vld = 1'b0;
        chk("mf_a_full", a_rdy, 0);
        rst = 1'b1;
        #1;
        chk("mf_rst_lft", lft_out, 0);
        chk("mf_rst_rht", rht_out, 0);
        chk("mf_rst_a_rdy", a_rdy, 1);
        chk("mf_rst_b_rdy", b_rdy, 1);
        chk("mf_rst_active", active_src, 0);
        chk("mf_rst_busy", busy, 0);
        chk("mf_rst_ur", underrun, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int t = 0; t < 2; t++) begin
            frame(1, 16'h4000, 16'h4000, 1, 16'h4000, 16'h4000);
            chk("silent_busy", busy, 0);
            chk("silent_lft", lft_out, 0);
            chk("silent_ur", underrun, 0);
        end

        // Rounding: gain 1 on the second FADE_IN tick.
        en = 1'b1; sel = 1'b0;
        frame(1, 16'hFFFF, 16'h000F, 0, 16'h0, 16'h0);
        chk("rnd_enter_busy", busy, 1);
        chk("rnd_enter_active", active_src, 0);
        frame(1, 16'hFFFF, 16'h000F, 0, 16'h0, 16'h0);
        chk("rnd_g0_lft", lft_out, 0);
        frame(1, 16'hFFFF, 16'h000F, 0, 16'h0, 16'h0);
        chk("rnd_neg1", lft_out, 16'hFFFF);
        chk("rnd_pos15", rht_out, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
